// File: rtl/clave_pkg.sv
// Shared types and defaults for the clave step sequencer.
// The default 3-2 clave pattern has hits on steps 0, 3, 6, 10 and 12.
package clave_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEF_STEPS = 16;
  localparam int DEF_TPS   = 412;
  localparam int DEF_WIDTH = 13;

  localparam logic [15:0] CLAVE_32 = 16'h1449;

  function automatic int bar_period(
    input int steps,
    input int tps
  );
    return steps * tps;
  endfunction

endpackage

// File: rtl/clave_step_sequencer_if.sv
// Control and status bundle between the timebase/judge logic
// and the step sequencer.
interface clave_step_sequencer_if
  import clave_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = DEF_STEPS,
  parameter int SW    = $clog2(STEPS)
);

  logic             go;
  logic             en;
  logic             pause;
  logic             loop;
  logic [STEPS-1:0] pattern;
  logic [WIDTH-1:0] count;
  logic [SW-1:0]    step;
  logic             hit;
  logic             wrap;
  logic             done;
  logic             busy;

  modport master (
    output go, en, pause, loop, pattern,
    input  count, step, hit, wrap, done, busy
  );

  modport slave (
    input  go, en, pause, loop, pattern,
    output count, step, hit, wrap, done, busy
  );

endinterface

// File: rtl/step_tick_divider.sv
// Sub-step tick counter: runs 0..TICKS_PER_STEP-1 on each advance.
// o_last flags the final tick of the step.
module step_tick_divider #(
  parameter int TICKS_PER_STEP = 412
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_last
);

  localparam int TW = $clog2(TICKS_PER_STEP);
  localparam logic [TW-1:0] SUB_MAX =
    TW'(TICKS_PER_STEP - 1);

  logic [TW-1:0] r_sub;

  assign o_last = (r_sub == SUB_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sub <= '0;
    end else if (i_clr) begin
      r_sub <= '0;
    end else if (i_adv) begin
      r_sub <= o_last ? '0 : r_sub + TW'(1);
    end
  end

endmodule

// File: rtl/clave_step_sequencer.sv
// Bar sequencer: counts enabled ticks over STEPS steps and pulses
// hit at the start of each patterned step, with pause/loop/one-shot.
module clave_step_sequencer
  import clave_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int STEPS          = DEF_STEPS,
  parameter int TICKS_PER_STEP = DEF_TPS
) (
  input logic clk,
  input logic resetn,
  clave_step_sequencer_if.slave bus
);

  localparam int SW     = $clog2(STEPS);
  localparam int PERIOD = bar_period(STEPS, TICKS_PER_STEP);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PERIOD - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic [SW-1:0]    r_step;
  logic [STEPS-1:0] r_pat;
  logic             r_hit;
  logic             r_wrap;
  logic             r_done;

  logic             w_adv;
  logic             w_last;
  logic             w_end;
  logic [SW-1:0]    w_step_nx;

  assign w_adv = (r_state == S_RUN) && bus.en
              && !bus.pause && !bus.go;
  assign w_end     = w_last && (r_step == LAST_STEP);
  assign w_step_nx = r_step + SW'(1);

  step_tick_divider #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_div (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (bus.go),
    .i_adv  (w_adv),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_step  <= '0;
      r_pat   <= '0;
      r_hit   <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      if (bus.go) begin
        r_state <= S_RUN;
        r_count <= '0;
        r_step  <= '0;
        r_pat   <= bus.pattern;
        r_hit   <= bus.pattern[0];
      end else begin
        unique case (r_state)
          S_RUN: begin
            if (bus.pause) begin
              r_state <= S_PAUSE;
            end else if (w_adv) begin
              if (w_end && bus.loop) begin
                r_count <= '0;
                r_step  <= '0;
                r_wrap  <= 1'b1;
                r_hit   <= r_pat[0];
              end else if (w_end) begin
                // one-shot: freeze on the final tick
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_count <= CNT_MAX;
              end else if (w_last) begin
                r_count <= r_count + WIDTH'(1);
                r_step  <= w_step_nx;
                r_hit   <= r_pat[w_step_nx];
              end else begin
                r_count <= r_count + WIDTH'(1);
              end
            end
          end
          S_PAUSE: begin
            if (!bus.pause) r_state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count = r_count;
  assign bus.step  = r_step;
  assign bus.hit   = r_hit;
  assign bus.wrap  = r_wrap;
  assign bus.done  = r_done;
  assign bus.busy  = (r_state == S_RUN)
                  || (r_state == S_PAUSE);

endmodule
